bsg_cgol_output: RTL and testbench

Board readout engine for the Game of Life array. Captures a flattened snapshot of every cell's state in one cycle, then streams it out one row per beat over a valid/yumi interface to the host-side consumer. It is the read end of the cell interface: cells are loaded through update/update-value, and this block unloads their state. It sits between the cell array and the output FIFO/host.

---
 rtl/bsg_cgol_pkg.sv | 21 ++
 rtl/bsg_cgol_row_popcount.sv | 26 ++
 rtl/bsg_cgol_output.sv | 113 +++++++++++
 tb/tb_bsg_cgol_output.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cgol_pkg.sv
`default_nettype none
// ============================================================================
// Module : bsg_cgol_pkg
// Brief  : Shared types and helpers for the Game of Life board readout path.
// Rev    : 1.0  initial release
// ============================================================================
package bsg_cgol_pkg;

  // Readout engine states: waiting for a snapshot, or streaming rows.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } cgol_out_state_e;

  // Bits needed to count 0..w live cells in one row.
  function automatic int cgol_popcount_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_cgol_row_popcount.sv
`default_nettype none
// ============================================================================
// Module : bsg_cgol_row_popcount
// Brief  : Counts the live cells in one board row.
// Rev    : 1.0  initial release
// ============================================================================
module bsg_cgol_row_popcount
  import bsg_cgol_pkg::*;
#(
  parameter int width_p = 8,
  localparam int CNT_W  = cgol_popcount_width(width_p)
) (
  input  logic [width_p-1:0] row_i,
  output logic [CNT_W-1:0]   count_o
);

  // Sum of all cell bits; the tool balances the additions into a tree.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < width_p; i++) begin
      count_o = count_o + CNT_W'(row_i[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_cgol_output.sv
`default_nettype none
// ============================================================================
// Module : bsg_cgol_output
// Brief  : Captures a full board snapshot in one cycle and streams it out
//          one row per beat over a valid/yumi handshake, row 0 first.
//          Optional macro CGOL_OUTPUT_POPCOUNT_EN adds popcount_o, the number
//          of live cells in the row currently presented.
// Rev    : 1.0  initial release
// ============================================================================
module bsg_cgol_output
  import bsg_cgol_pkg::*;
#(
  parameter int board_width_p = 8
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   v_i,
  input  logic [board_width_p*board_width_p-1:0] data_i,
  output logic                                   ready_o,
  output logic                                   v_o,
  output logic [board_width_p-1:0]               data_o,
  output logic                                   last_o,
  input  logic                                   yumi_i
`ifdef CGOL_OUTPUT_POPCOUNT_EN
  ,
  output logic [cgol_popcount_width(board_width_p)-1:0] popcount_o
`endif
);

  localparam int BOARD_BITS = board_width_p * board_width_p;
  localparam int ROW_W      = (board_width_p > 1) ? $clog2(board_width_p) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(board_width_p - 1);

  cgol_out_state_e        state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [BOARD_BITS-1:0]  snapshot_q, snapshot_d;
  logic [board_width_p-1:0] row_sel;
  logic                   at_last_row;

  // State, row counter and snapshot registers; reset discards any snapshot.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      row_q      <= '0;
      snapshot_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      snapshot_q <= snapshot_d;
    end
  end

  assign at_last_row = (row_q == LAST_ROW);

  // Next-state logic: accept only in IDLE, advance the row only on yumi.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    snapshot_d = snapshot_q;
    case (state_q)
      IDLE: begin
        if (v_i) begin
          snapshot_d = data_i;
          row_d      = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (yumi_i) begin
          if (at_last_row) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        row_d   = '0;
      end
    endcase
  end

  // Select the snapshot row addressed by the row counter.
  always_comb begin
    row_sel = '0;
    for (int r = 0; r < board_width_p; r++) begin
      if (row_q == ROW_W'(r)) begin
        row_sel = snapshot_q[r*board_width_p +: board_width_p];
      end
    end
  end

  // Outputs decode registered state only; data is forced to zero outside SEND
  // so nothing stale is visible after reset or between snapshots.
  assign ready_o = (state_q == IDLE);
  assign v_o     = (state_q == SEND);
  assign last_o  = (state_q == SEND) && at_last_row;
  assign data_o  = (state_q == SEND) ? row_sel : '0;

`ifdef CGOL_OUTPUT_POPCOUNT_EN
  // data_o is already zero outside SEND, so the count is zero there too.
  bsg_cgol_row_popcount #(
    .width_p (board_width_p)
  ) u_row_popcount (
    .row_i   (data_o),
    .count_o (popcount_o)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_cgol_output.sv
`default_nettype none
// ============================================================================
// Module : tb_bsg_cgol_output
// Brief  : Scoreboard bench for bsg_cgol_output at board widths 4 and 1.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bsg_cgol_output;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Width-4 instance
  logic        reset4, v4, yumi4, ready4, vo4, last4;
  logic [15:0] din4;
  logic [3:0]  dout4;
  // Width-1 instance
  logic        reset1, v1, yumi1, ready1, vo1, last1;
  logic        din1;
  logic        dout1;
`ifdef CGOL_OUTPUT_POPCOUNT_EN
  logic [2:0]  pc4;
  logic        pc1;
`endif

  bsg_cgol_output #(.board_width_p(4)) dut4 (
    .clk_i   (clk),
    .reset_i (reset4),
    .v_i     (v4),
    .data_i  (din4),
    .ready_o (ready4),
    .v_o     (vo4),
    .data_o  (dout4),
    .last_o  (last4),
    .yumi_i  (yumi4)
`ifdef CGOL_OUTPUT_POPCOUNT_EN
    ,
    .popcount_o (pc4)
`endif
  );

  bsg_cgol_output #(.board_width_p(1)) dut1 (
    .clk_i   (clk),
    .reset_i (reset1),
    .v_i     (v1),
    .data_i  (din1),
    .ready_o (ready1),
    .v_o     (vo1),
    .data_o  (dout1),
    .last_o  (last1),
    .yumi_i  (yumi1)
`ifdef CGOL_OUTPUT_POPCOUNT_EN
    ,
    .popcount_o (pc1)
`endif
  );

  typedef struct packed {
    logic [3:0] row;
    logic       last;
    logic [3:0] pc;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push4(input logic [3:0] r, input logic l, input logic [3:0] p);
    exp_t e;
    e.row = r; e.last = l; e.pc = p;
    q4.push_back(e);
  endtask

  task automatic push1(input logic r, input logic l, input logic [3:0] p);
    exp_t e;
    e.row = {3'b000, r}; e.last = l; e.pc = p;
    q1.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Monitor for the width-4 instance: every presented beat must match the
  // head of the queue (so held rows stay stable); yumi pops it.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!reset4) begin
      if (yumi4) chk("w4 yumi while v_o low", 32'(vo4), 32'd1);
      if (vo4) begin
        if (q4.size() == 0) begin
          chk("w4 unexpected beat", 32'(dout4), 32'hFFFF_FFFF);
        end else begin
          e = q4[0];
          chk("w4 row", 32'(dout4), 32'(e.row));
          chk("w4 last", 32'(last4), 32'(e.last));
`ifdef CGOL_OUTPUT_POPCOUNT_EN
          chk("w4 popcount", 32'(pc4), 32'(e.pc));
`endif
          if (yumi4) void'(q4.pop_front());
        end
      end
    end
  end

  // Monitor for the width-1 instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!reset1) begin
      if (yumi1) chk("w1 yumi while v_o low", 32'(vo1), 32'd1);
      if (vo1) begin
        if (q1.size() == 0) begin
          chk("w1 unexpected beat", 32'(dout1), 32'hFFFF_FFFF);
        end else begin
          e = q1[0];
          chk("w1 row", 32'(dout1), 32'(e.row));
          chk("w1 last", 32'(last1), 32'(e.last));
`ifdef CGOL_OUTPUT_POPCOUNT_EN
          chk("w1 popcount", 32'(pc1), 32'(e.pc));
`endif
          if (yumi1) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat [7];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    reset4 = 1'b1; v4 = 1'b0; yumi4 = 1'b0; din4 = '0;
    reset1 = 1'b1; v1 = 1'b0; yumi1 = 1'b0; din1 = 1'b0;
    step; step;
    reset4 = 1'b0; reset1 = 1'b0;

    // Reset state and idle hold
    for (int i = 0; i < 10; i++) begin
      chk("idle ready_o", 32'(ready4), 32'd1);
      chk("idle v_o", 32'(vo4), 32'd0);
      chk("idle data_o", 32'(dout4), 32'd0);
      chk("idle last_o", 32'(last4), 32'd0);
`ifdef CGOL_OUTPUT_POPCOUNT_EN
      chk("idle popcount_o", 32'(pc4), 32'd0);
`endif
      step;
    end

    // Full-rate stream of 16'hA5C3
    push4(4'h3, 1'b0, 4'd2); push4(4'hC, 1'b0, 4'd2);
    push4(4'h5, 1'b0, 4'd2); push4(4'hA, 1'b1, 4'd2);
    v4 = 1'b1; din4 = 16'hA5C3; step;
    v4 = 1'b0; din4 = '0; yumi4 = 1'b1;
    chk("latency v_o", 32'(vo4), 32'd1);
    chk("send ready_o", 32'(ready4), 32'd0);
    repeat (4) step;
    yumi4 = 1'b0;
    chk("ready after last", 32'(ready4), 32'd1);
    chk("v_o after last", 32'(vo4), 32'd0);

    // Backpressure with yumi pattern 1,0,0,1,1,0,1
    push4(4'h3, 1'b0, 4'd2); push4(4'hC, 1'b0, 4'd2);
    push4(4'h5, 1'b0, 4'd2); push4(4'hA, 1'b1, 4'd2);
    v4 = 1'b1; din4 = 16'hA5C3; step;
    v4 = 1'b0; din4 = '0;
    for (int i = 0; i < 7; i++) begin
      yumi4 = pat[i];
      step;
    end
    yumi4 = 1'b0;
    chk("bp ready after last", 32'(ready4), 32'd1);

    // Request during SEND is ignored
    push4(4'h1, 1'b0, 4'd1); push4(4'h0, 1'b0, 4'd0);
    push4(4'h0, 1'b0, 4'd0); push4(4'h0, 1'b1, 4'd0);
    v4 = 1'b1; din4 = 16'h0001; step;
    din4 = 16'hFFFF; yumi4 = 1'b1;
    repeat (4) step;
    v4 = 1'b0; din4 = '0; yumi4 = 1'b0;
    chk("ignore v_o", 32'(vo4), 32'd0);
    chk("ignore ready_o", 32'(ready4), 32'd1);
    step;
    chk("ignore still idle", 32'(vo4), 32'd0);

    // Reset mid-stream after row 1
    push4(4'h3, 1'b0, 4'd2); push4(4'hC, 1'b0, 4'd2);
    v4 = 1'b1; din4 = 16'hA5C3; step;
    v4 = 1'b0; din4 = '0; yumi4 = 1'b1;
    step; step;
    yumi4 = 1'b0; reset4 = 1'b1; v4 = 1'b1; din4 = 16'hFFFF;
    step;
    reset4 = 1'b0; v4 = 1'b0; din4 = '0;
    chk("post-reset v_o", 32'(vo4), 32'd0);
    chk("post-reset ready_o", 32'(ready4), 32'd1);
    chk("post-reset data_o", 32'(dout4), 32'd0);
    push4(4'h4, 1'b0, 4'd1); push4(4'h3, 1'b0, 4'd2);
    push4(4'h2, 1'b0, 4'd1); push4(4'h1, 1'b1, 4'd1);
    v4 = 1'b1; din4 = 16'h1234; step;
    v4 = 1'b0; din4 = '0; yumi4 = 1'b1;
    repeat (4) step;
    yumi4 = 1'b0;
    chk("1234 ready after last", 32'(ready4), 32'd1);

    // Width-1 board: single beat, back-to-back requests 2 cycles apart
    push1(1'b1, 1'b1, 4'd1); push1(1'b0, 1'b1, 4'd0);
    v1 = 1'b1; din1 = 1'b1; step;
    chk("w1 v_o", 32'(vo1), 32'd1);
    chk("w1 ready_o busy", 32'(ready1), 32'd0);
    yumi1 = 1'b1; din1 = 1'b0; step;
    yumi1 = 1'b0;
    chk("w1 ready_o again", 32'(ready1), 32'd1);
    step;
    v1 = 1'b0;
    chk("w1 second accept", 32'(vo1), 32'd1);
    yumi1 = 1'b1; step;
    yumi1 = 1'b0;
    chk("w1 final ready_o", 32'(ready1), 32'd1);
    chk("w1 final v_o", 32'(vo1), 32'd0);

    step; step;
    chk("w4 beats outstanding", 32'(q4.size()), 32'd0);
    chk("w1 beats outstanding", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
